// File: rtl/multi_cycle_ctrl.sv
// Multi-cycle control FSM for the shared single-ALU / single-memory MIPS datapath.
// State and the memory wait counter are registered; control outputs are decoded from state and live inputs.
module multi_cycle_ctrl #(
  parameter int unsigned MEM_TIMEOUT = 16,
  parameter int unsigned CNT_W       = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [5:0] Op,
  input  logic [5:0] Funct,
  input  logic       Zero,
  input  logic       MemReady,
  output logic       PCWrite,
  output logic       IRWrite,
  output logic       RegWrite,
  output logic       MemRead,
  output logic       MemWrite,
  output logic       EXTOp,
  output logic [3:0] ALUOp,
  output logic [1:0] NPCOp,
  output logic       ALUSrc,
  output logic [1:0] GPRSel,
  output logic [1:0] WDSel,
  output logic       InstDone,
  output logic       IllegalInst,
  output logic       MemErr,
  output logic [3:0] State
);

  typedef enum logic [3:0] {
    S_FETCH  = 4'd0, S_DECODE = 4'd1, S_EXE    = 4'd2, S_ALU_WB = 4'd3, S_ADDR = 4'd4,
    S_MEM_RD = 4'd5, S_MEM_WB = 4'd6, S_MEM_WR = 4'd7, S_BRANCH = 4'd8, S_JUMP = 4'd9
  } state_t;

  typedef enum logic [2:0] {C_ILLEGAL, C_ALU, C_MEM, C_BRANCH, C_JUMP} iclass_t;

  typedef struct packed {
    iclass_t    iclass;
    logic [3:0] alu_op;
    logic       alu_src;
    logic       ext_op;
    logic       imm;
  } dec_t;

  localparam logic [5:0] OP_RTYPE = 6'h00, OP_J  = 6'h02, OP_JAL = 6'h03, OP_BEQ = 6'h04;
  localparam logic [5:0] OP_ADDI  = 6'h08, OP_ORI = 6'h0D, OP_LW = 6'h23, OP_SW  = 6'h2B;

  localparam logic [3:0] ALU_NOP = 4'd0, ALU_ADD = 4'd1, ALU_SUB = 4'd2, ALU_AND  = 4'd3;
  localparam logic [3:0] ALU_OR  = 4'd4, ALU_SLT = 4'd5, ALU_SLTU = 4'd6, ALU_SLL = 4'd7;

  localparam logic [1:0] NPC_PLUS4 = 2'd0, NPC_BRANCH = 2'd1, NPC_JUMP = 2'd2;
  localparam logic [1:0] GPR_RD = 2'd0, GPR_RT = 2'd1, GPR_RA = 2'd2;
  localparam logic [1:0] WD_ALU = 2'd0, WD_MEM = 2'd1, WD_PC  = 2'd2;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MEM_TIMEOUT == 0 ? 0 : MEM_TIMEOUT - 1);

  function automatic dec_t decode(input logic [5:0] op, input logic [5:0] funct);
    dec_t d;
    d.iclass  = C_ILLEGAL;
    d.alu_op  = ALU_NOP;
    d.alu_src = 1'b0;
    d.ext_op  = 1'b0;
    d.imm     = 1'b0;
    case (op)
      OP_RTYPE: begin
        d.iclass = C_ALU;
        case (funct)
          6'h20, 6'h21: d.alu_op = ALU_ADD;
          6'h22, 6'h23: d.alu_op = ALU_SUB;
          6'h24:        d.alu_op = ALU_AND;
          6'h25:        d.alu_op = ALU_OR;
          6'h2A:        d.alu_op = ALU_SLT;
          6'h2B:        d.alu_op = ALU_SLTU;
          6'h00:        d.alu_op = ALU_SLL;
          default:      d.iclass = C_ILLEGAL;
        endcase
      end
      OP_ADDI: begin
        d.iclass  = C_ALU;
        d.alu_op  = ALU_ADD;
        d.alu_src = 1'b1;
        d.ext_op  = 1'b1;
        d.imm     = 1'b1;
      end
      OP_ORI: begin
        d.iclass  = C_ALU;
        d.alu_op  = ALU_OR;
        d.alu_src = 1'b1;
        d.imm     = 1'b1;
      end
      OP_LW, OP_SW: d.iclass = C_MEM;
      OP_BEQ:       d.iclass = C_BRANCH;
      OP_J, OP_JAL: d.iclass = C_JUMP;
      default:      d.iclass = C_ILLEGAL;
    endcase
    return d;
  endfunction

  state_t           state;
  logic [CNT_W-1:0] wait_cnt;
  dec_t             dec;
  logic             waiting;
  logic             expire;

  assign dec     = decode(Op, Funct);
  assign waiting = (state == S_FETCH) || (state == S_MEM_RD) || (state == S_MEM_WR);
  // MemReady in the expiry cycle wins, so expiry requires it low.
  assign expire  = (MEM_TIMEOUT != 0) && waiting && !MemReady && (wait_cnt == CNT_LAST);

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= S_FETCH;
      wait_cnt <= '0;
    end else begin
      // Counting only while parked in a wait state also clears it on every entry and exit.
      wait_cnt <= (waiting && !MemReady && !expire) ? wait_cnt + 1'b1 : '0;
      case (state)
        S_FETCH:  if (MemReady) state <= S_DECODE;
        S_DECODE: begin
          case (dec.iclass)
            C_ALU:    state <= S_EXE;
            C_MEM:    state <= S_ADDR;
            C_BRANCH: state <= S_BRANCH;
            C_JUMP:   state <= S_JUMP;
            default:  state <= S_FETCH;
          endcase
        end
        S_EXE:    state <= S_ALU_WB;
        S_ADDR:   state <= (Op == OP_SW) ? S_MEM_WR : S_MEM_RD;
        S_MEM_RD: begin
          if (MemReady)    state <= S_MEM_WB;
          else if (expire) state <= S_FETCH;
        end
        S_MEM_WR: if (MemReady || expire) state <= S_FETCH;
        default:  state <= S_FETCH;
      endcase
    end
  end

  always_comb begin
    // NOTE: every output gets a default before the case so no path can infer a latch.
    PCWrite     = 1'b0;
    IRWrite     = 1'b0;
    RegWrite    = 1'b0;
    MemRead     = 1'b0;
    MemWrite    = 1'b0;
    EXTOp       = 1'b0;
    ALUOp       = ALU_NOP;
    NPCOp       = NPC_PLUS4;
    ALUSrc      = 1'b0;
    GPRSel      = GPR_RD;
    WDSel       = WD_ALU;
    InstDone    = 1'b0;
    IllegalInst = 1'b0;
    MemErr      = 1'b0;
    State       = 4'd0;
    if (!rst) begin
      State = state;
      case (state)
        S_FETCH: begin
          MemRead = 1'b1;
          IRWrite = MemReady;
          PCWrite = MemReady;
          MemErr  = expire;
        end
        S_DECODE: IllegalInst = (dec.iclass == C_ILLEGAL);
        S_EXE: begin
          ALUOp  = dec.alu_op;
          ALUSrc = dec.alu_src;
          EXTOp  = dec.ext_op;
        end
        S_ALU_WB: begin
          ALUOp    = dec.alu_op;
          ALUSrc   = dec.alu_src;
          EXTOp    = dec.ext_op;
          RegWrite = 1'b1;
          GPRSel   = dec.imm ? GPR_RT : GPR_RD;
          InstDone = 1'b1;
        end
        S_ADDR: begin
          ALUOp  = ALU_ADD;
          ALUSrc = 1'b1;
          EXTOp  = 1'b1;
        end
        S_MEM_RD: begin
          MemRead = 1'b1;
          ALUOp   = ALU_ADD;
          ALUSrc  = 1'b1;
          EXTOp   = 1'b1;
          MemErr  = expire;
        end
        S_MEM_WB: begin
          RegWrite = 1'b1;
          GPRSel   = GPR_RT;
          WDSel    = WD_MEM;
          InstDone = 1'b1;
        end
        S_MEM_WR: begin
          MemWrite = 1'b1;
          ALUOp    = ALU_ADD;
          ALUSrc   = 1'b1;
          EXTOp    = 1'b1;
          InstDone = MemReady;
          MemErr   = expire;
        end
        S_BRANCH: begin
          ALUOp    = ALU_SUB;
          EXTOp    = 1'b1;
          NPCOp    = NPC_BRANCH;
          PCWrite  = Zero;
          InstDone = 1'b1;
        end
        S_JUMP: begin
          PCWrite  = 1'b1;
          NPCOp    = NPC_JUMP;
          InstDone = 1'b1;
          if (Op == OP_JAL) begin
            RegWrite = 1'b1;
            GPRSel   = GPR_RA;
            WDSel    = WD_PC;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
